// File: rtl/decimal_to_bin_if.sv
// Valid/ready handshake bundle for the BCD-to-binary converter.
// Slave is the converter; master is whoever supplies digits and consumes results.
interface decimal_to_bin_if #(
    parameter int unsigned BW = 8
);
    logic [3:0]    tens_i;
    logic [3:0]    ones_i;
    logic          valid_i;
    logic          ready_o;
    logic [BW-1:0] bin_o;
    logic          err_o;
    logic          valid_o;
    logic          ready_i;

    modport slave (
        input  tens_i,
        input  ones_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output bin_o,
        output err_o,
        output valid_o
    );

    modport master (
        output tens_i,
        output ones_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  bin_o,
        input  err_o,
        input  valid_o
    );
endinterface

// File: rtl/decimal_to_bin.sv
// Two-digit BCD to binary converter using iterative reverse double-dabble,
// one shift/correct step per clock, with valid/ready on both sides.
module decimal_to_bin #(
    parameter int unsigned BW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    decimal_to_bin_if.slave bus
);
    localparam int unsigned DW = 8;
    localparam int unsigned WW = DW + BW;
    localparam int unsigned CW = $clog2(BW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [WW-1:0] work_q,  work_n;
    logic [CW-1:0] cnt_q,   cnt_n;
    logic [BW-1:0] bin_q,   bin_n;
    logic          err_q,   err_n;
    logic          ready_q, ready_n;
    logic          valid_q, valid_n;

    logic          digits_ok_c;
    logic [WW-1:0] shift_c;
    logic [WW-1:0] step_c;

    assign digits_ok_c = (bus.tens_i <= 4'd9) && (bus.ones_i <= 4'd9);

    // One reverse double-dabble step: halve, then undo the 8-vs-5 weight of any borrowed bit.
    always_comb begin
        shift_c = work_q >> 1;
        step_c  = shift_c;
        for (int i = 0; i < 2; i++) begin
            if (shift_c[BW + 4*i + 3 -: 4] >= 4'd8) begin
                step_c[BW + 4*i + 3 -: 4] = shift_c[BW + 4*i + 3 -: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            work_q  <= work_n;
            cnt_q   <= cnt_n;
            bin_q   <= bin_n;
            err_q   <= err_n;
            ready_q <= ready_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state_q;
        work_n  = work_q;
        cnt_n   = cnt_q;
        bin_n   = bin_q;
        err_n   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    if (digits_ok_c) begin
                        work_n  = {bus.tens_i, bus.ones_i, {BW{1'b0}}};
                        cnt_n   = '0;
                        state_n = CONV;
                    end else begin
                        bin_n   = '0;
                        err_n   = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            CONV: begin
                work_n = step_c;
                cnt_n  = cnt_q + CW'(1);
                if (cnt_q == CW'(BW - 1)) begin
                    bin_n   = step_c[BW-1:0];
                    err_n   = 1'b0;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next-state decode.
        ready_n = (state_n == IDLE);
        valid_n = (state_n == DONE);
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.bin_o   = bin_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_decimal_to_bin.sv
// Self-checking bench for decimal_to_bin: directed scenarios plus randomized
// transactions compared against an arithmetic model of BCD-to-binary conversion.
module tb_decimal_to_bin;
    localparam int unsigned BW = 8;

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    decimal_to_bin_if #(.BW(BW)) bus ();

    decimal_to_bin #(.BW(BW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic int model_bin(input int t, input int o);
        return (t > 9 || o > 9) ? 0 : 10 * t + o;
    endfunction

    function automatic int model_err(input int t, input int o);
        return (t > 9 || o > 9) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Steps clock edges until valid_o is seen; n = edges taken, -1 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.valid_o !== 1'b1 && n < 64);
        if (bus.valid_o !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        bus.tens_i  = 4'd0;
        bus.ones_i  = 4'd0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        #3;
        checks++;
        if (bus.bin_o !== 8'd0 || bus.err_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got bin=%0d err=%0b valid=%0b exp 0/0/0", bus.bin_o, bus.err_o, bus.valid_o);
        end
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        tick();
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%0b valid=%0b exp 1/0", bus.ready_o, bus.valid_o);
        end
    endtask

    task automatic test_basic();
        bus.tens_i  = 4'd4;
        bus.ones_i  = 4'd2;
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept got ready=%0b valid=%0b exp 0/0", bus.ready_o, bus.valid_o);
        end
        for (int k = 1; k < int'(BW); k++) begin
            tick();
            checks++;
            if (bus.valid_o !== 1'b0) begin
                errors++;
                $display("FAIL basic_early_valid cycle %0d got valid=%0b exp 0", k, bus.valid_o);
            end
        end
        tick();
        checks++;
        if (bus.valid_o !== 1'b1 || bus.bin_o !== 8'h2A || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got valid=%0b bin=%0h err=%0b exp 1/2a/0", bus.valid_o, bus.bin_o, bus.err_o);
        end
        tick();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_return got valid=%0b ready=%0b exp 0/1", bus.valid_o, bus.ready_o);
        end
    endtask

    task automatic test_sweep();
        int n;
        int exp_n;
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.tens_i  = 4'd0;
        bus.ones_i  = 4'd0;
        for (int idx = 0; idx < 100; idx++) begin
            wait_valid(n);
            exp_n = (idx == 0) ? int'(BW) + 1 : int'(BW) + 2;
            checks++;
            if (n !== exp_n) begin
                errors++;
                $display("FAIL sweep_spacing idx %0d got %0d edges exp %0d", idx, n, exp_n);
            end
            checks++;
            if (bus.bin_o !== BW'(idx) || bus.err_o !== 1'b0) begin
                errors++;
                $display("FAIL sweep_value idx %0d got bin=%0d err=%0b exp %0d/0", idx, bus.bin_o, bus.err_o, idx);
            end
            // Next digits go up while in DONE; they are taken one edge after the return to IDLE.
            bus.tens_i = 4'((idx + 1) / 10);
            bus.ones_i = 4'((idx + 1) % 10);
        end
        bus.valid_i = 1'b0;
        tick();
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL sweep_idle got ready=%0b exp 1", bus.ready_o);
        end
    endtask

    task automatic test_invalid();
        int n;
        bus.ready_i = 1'b1;
        bus.tens_i  = 4'hA;
        bus.ones_i  = 4'd3;
        bus.valid_i = 1'b1;
        wait_valid(n);
        bus.valid_i = 1'b0;
        checks++;
        if (n !== 1 || bus.bin_o !== 8'd0 || bus.err_o !== 1'b1) begin
            errors++;
            $display("FAIL invalid_digit got edges=%0d bin=%0d err=%0b exp 1/0/1", n, bus.bin_o, bus.err_o);
        end
        tick();
        bus.tens_i  = 4'd1;
        bus.ones_i  = 4'd5;
        bus.valid_i = 1'b1;
        wait_valid(n);
        bus.valid_i = 1'b0;
        checks++;
        if (n !== int'(BW) + 1 || bus.bin_o !== 8'h0F || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_recover got edges=%0d bin=%0h err=%0b exp %0d/f/0", n, bus.bin_o, bus.err_o, BW + 1);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        bus.ready_i = 1'b0;
        bus.tens_i  = 4'd9;
        bus.ones_i  = 4'd9;
        bus.valid_i = 1'b1;
        wait_valid(n);
        bus.tens_i = 4'd1;
        bus.ones_i = 4'd1;
        checks++;
        if (n !== int'(BW) + 1 || bus.bin_o !== 8'h63) begin
            errors++;
            $display("FAIL bp_result got edges=%0d bin=%0h exp %0d/63", n, bus.bin_o, BW + 1);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.bin_o !== 8'h63 || bus.err_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%0b ready=%0b bin=%0h err=%0b exp 1/0/63/0",
                         k, bus.valid_o, bus.ready_o, bus.bin_o, bus.err_o);
            end
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        tick();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.bin_o !== 8'h63) begin
            errors++;
            $display("FAIL bp_release got valid=%0b ready=%0b bin=%0h exp 0/1/63", bus.valid_o, bus.ready_o, bus.bin_o);
        end
    endtask

    task automatic test_async_reset();
        int n;
        bus.ready_i = 1'b1;
        bus.tens_i  = 4'd5;
        bus.ones_i  = 4'd7;
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        repeat (4) tick();
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (bus.bin_o !== 8'd0 || bus.err_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_outputs got bin=%0h err=%0b valid=%0b ready=%0b exp 0/0/0/1",
                     bus.bin_o, bus.err_o, bus.valid_o, bus.ready_o);
        end
        #3 rst_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
                errors++;
                $display("FAIL areset_no_pulse cycle %0d got valid=%0b ready=%0b exp 0/1", k, bus.valid_o, bus.ready_o);
            end
        end
        bus.valid_i = 1'b1;
        wait_valid(n);
        bus.valid_i = 1'b0;
        checks++;
        if (n !== int'(BW) + 1 || bus.bin_o !== 8'h39 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL areset_redo got edges=%0d bin=%0h err=%0b exp %0d/39/0", n, bus.bin_o, bus.err_o, BW + 1);
        end
        tick();
    endtask

    task automatic test_done_collision();
        int n;
        bus.ready_i = 1'b0;
        bus.tens_i  = 4'd2;
        bus.ones_i  = 4'd0;
        bus.valid_i = 1'b1;
        wait_valid(n);
        checks++;
        if (bus.bin_o !== 8'd20) begin
            errors++;
            $display("FAIL coll_first got bin=%0d exp 20", bus.bin_o);
        end
        bus.tens_i  = 4'd3;
        bus.ones_i  = 4'd0;
        bus.ready_i = 1'b1;
        tick();
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.bin_o !== 8'd20) begin
            errors++;
            $display("FAIL coll_idle got ready=%0b valid=%0b bin=%0d exp 1/0/20", bus.ready_o, bus.valid_o, bus.bin_o);
        end
        tick();
        bus.valid_i = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL coll_accept got ready=%0b exp 0", bus.ready_o);
        end
        wait_valid(n);
        checks++;
        if (n !== int'(BW) || bus.bin_o !== 8'h1E || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL coll_result got edges=%0d bin=%0h err=%0b exp %0d/1e/0", n, bus.bin_o, bus.err_o, BW);
        end
        tick();
    endtask

    task automatic test_random();
        int n;
        int t;
        int o;
        int stall;
        int exp_bin;
        int exp_err;
        int exp_n;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                t = int'($urandom_range(0, 15));
                o = int'($urandom_range(0, 15));
            end else begin
                t = int'($urandom_range(0, 9));
                o = int'($urandom_range(0, 9));
            end
            exp_bin = model_bin(t, o);
            exp_err = model_err(t, o);
            exp_n   = (exp_err != 0) ? 1 : int'(BW) + 1;
            stall   = int'($urandom_range(0, 3));
            bus.tens_i  = 4'(t);
            bus.ones_i  = 4'(o);
            bus.valid_i = 1'b1;
            bus.ready_i = (stall == 0);
            wait_valid(n);
            bus.tens_i = 4'($urandom_range(0, 15));
            bus.ones_i = 4'($urandom_range(0, 15));
            checks++;
            if (n !== exp_n || bus.bin_o !== BW'(exp_bin) || bus.err_o !== 1'(exp_err)) begin
                errors++;
                $display("FAIL rand_result it %0d digits %0d/%0d got edges=%0d bin=%0d err=%0b exp %0d/%0d/%0d",
                         it, t, o, n, bus.bin_o, bus.err_o, exp_n, exp_bin, exp_err);
            end
            for (int k = 0; k < stall; k++) begin
                tick();
                checks++;
                if (bus.valid_o !== 1'b1 || bus.bin_o !== BW'(exp_bin)) begin
                    errors++;
                    $display("FAIL rand_stall it %0d got valid=%0b bin=%0d exp 1/%0d", it, bus.valid_o, bus.bin_o, exp_bin);
                end
            end
            bus.valid_i = 1'b0;
            bus.ready_i = 1'b1;
            tick();
            checks++;
            if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.bin_o !== BW'(exp_bin) || bus.err_o !== 1'(exp_err)) begin
                errors++;
                $display("FAIL rand_persist it %0d got ready=%0b valid=%0b bin=%0d err=%0b exp 1/0/%0d/%0d",
                         it, bus.ready_o, bus.valid_o, bus.bin_o, bus.err_o, exp_bin, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_invalid();
        test_backpressure();
        test_async_reset();
        test_done_collision();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/decimal_to_bin.md
Name: decimal_to_bin

Overview:
- Multi-cycle converter from a two-digit BCD value (tens, ones) to an unsigned binary number.
- Uses the iterative reverse double-dabble algorithm: one shift per clock.
- Sits between the scoreboard's decimal entry or display path and the binary score registers.
- Input and output both use valid/ready handshakes, so upstream and downstream blocks can stall it.

Parameters:
- BW, 8, width of the binary result and the number of conversion iterations. Legal range 7..16; bits above the value are zero.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  reset, asynchronous, active high
- tens_i  input  4  BCD tens digit
- ones_i  input  4  BCD ones digit
- valid_i  input  1  input digits valid
- ready_o  output  1  block can accept input; high only in IDLE
- bin_o  output  BW  binary result, equal to 10*tens + ones
- err_o  output  1  last request had an invalid digit (>9)
- valid_o  output  1  bin_o/err_o valid; high only in DONE
- ready_i  input  1  downstream accepts the result

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - state goes to IDLE; internal shift register and counter clear to 0.
  - Outputs: bin_o=0, err_o=0, valid_o=0, ready_o=1 (as soon as rst_i is released).
- States: IDLE, CONV, DONE. ready_o = (state==IDLE); valid_o = (state==DONE); both are decoded from the state register with no combinational path from inputs.
- IDLE, on an edge with valid_i=1:
  - Digits valid: load the 16-bit work register as {tens_i, ones_i, 8'b0} extended to {8-bit BCD, BW-bit binary}; clear the counter; go to CONV.
  - Either digit >9: do not convert; set bin_o=0, err_o=1; go to DONE. Latency is 1 cycle.
- CONV, one iteration per edge:
  - Shift the whole work register right by 1.
  - Then, for each 4-bit BCD nibble, subtract 3 if the nibble is >=8.
  - Increment the counter.
  - After iteration BW (counter == BW-1 on that edge), load bin_o from the binary field, clear err_o, go to DONE.
- Latency: input accepted at edge E0; valid_o is high in the cycle after edge E0+BW (8 cycles for the default).
- DONE:
  - bin_o and err_o are held stable.
  - On an edge with ready_i=1, go to IDLE.
  - With ready_i=0, stay in DONE indefinitely.
- Simultaneous events:
  - In DONE with ready_i=1 and valid_i=1: the block only returns to IDLE. The new input is not taken (ready_o=0 that cycle) and is accepted at the next edge if valid_i is still high.
  - valid_i and input digit changes during CONV/DONE are ignored; the captured values are used.
- Output persistence: bin_o/err_o update only on entry to DONE and keep their last value through IDLE and CONV until the next result.
- Maximum valid input 99 gives 0x63. The result always fits in 7 bits; no overflow condition exists.
- Throughput: one conversion per BW+2 cycles at best (accept, BW iterations, handshake).

Test Plan:
- Reset, then tens=4, ones=2, valid_i pulse, ready_i=1 → ready_o drops the next cycle; valid_o=1 exactly 8 cycles after the accept edge; bin_o=0x2A, err_o=0; back to IDLE one cycle later.
- Sweep all 100 valid pairs 0/0..9/9 back-to-back with valid_i held high → each bin_o equals 10*tens+ones (0x00..0x63); err_o=0; accepts spaced 10 cycles apart.
- tens=0xA, ones=3 → valid_o one cycle after the accept edge, bin_o=0, err_o=1. A following 1/5 request → bin_o=0x0F, err_o=0.
- Backpressure: 9/9 with ready_i=0 for 5 cycles after valid_o rises → valid_o, bin_o=0x63 and ready_o=0 held; digits changed to 1/1 during the stall are ignored; completes when ready_i=1.
- Assert rst_i asynchronously (between clock edges) at iteration 4 of a 5/7 conversion → outputs zero immediately and ready_o=1 after release; no valid_o pulse. A new 5/7 request → bin_o=0x39.
- In DONE with ready_i=1 and valid_i=1 (3/0) on the same edge → the block enters IDLE and the input is accepted one edge later; result bin_o=0x1E.
